// File: rtl/irb_pkg.sv
// -----------------------------------------------------------------------------
// irb_pkg
// Shared constants and types for the IRB front end. The FMI tile geometry,
// pixel width, halo size and the outstanding-read limit of the tile loader
// live here so the loader and its address FIFO agree on every width.
// No ports (package).
// -----------------------------------------------------------------------------
package irb_pkg;

    localparam int PX_W       = 16;                   // pixel width
    localparam int TIX        = 5;                    // tile width  (Tix_T)
    localparam int TIY        = 5;                    // tile height (Tiy_T)
    localparam int TIF        = 16;                   // max input channels (Tif)
    localparam int NKX        = 3;                    // depthwise kernel width
    localparam int PAD        = (NKX - 1) / 2;        // halo on each side
    localparam int MAX_OUT    = 4;                    // max reads in flight
    localparam int FMI_N_ELEM = TIX * TIY * TIF;      // FMI tile RAM entries
    localparam int FMI_AW     = $clog2(FMI_N_ELEM);   // FMI tile RAM address width

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } fmil_state_t;

endpackage

// File: rtl/irb_addr_fifo.sv
// -----------------------------------------------------------------------------
// irb_addr_fifo
// Small synchronous FIFO holding the FMI RAM address of every read request
// that has been accepted by memory but not yet answered. Responses come back
// in order, so the head entry is always the destination of the next response.
// Ports:
//   clk, rst    clock, synchronous active-high reset (empties the FIFO)
//   push, din   write one entry
//   pop, dout   drop the head entry; dout shows the head (valid when !empty)
//   full, empty occupancy flags
//   count       current number of entries (0..DEPTH)
// -----------------------------------------------------------------------------
module irb_addr_fifo
    import irb_pkg::*;
#(
    parameter int W     = FMI_AW,
    parameter int DEPTH = MAX_OUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define which entries are meaningful, so clearing them is enough.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fmi_tile_loader.sv
// -----------------------------------------------------------------------------
// fmi_tile_loader
// Fetches one input feature-map tile (TIX x TIY pixels x nif channels) from
// external memory into the FMI tile RAM, writing zeros for the halo pixels
// that fall outside the image. Read requests and responses are decoupled:
// up to MAX_OUT reads may be in flight, their RAM destinations queued in
// irb_addr_fifo.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start                       one-cycle pulse, accepted only when idle
//   cfg_base/nif/nix/niy/tx/ty  tile configuration, captured on start
//   busy, done                  status; done pulses after the last RAM write
//   rd_req_valid/ready, rd_addr read-request handshake (registered request)
//   rd_data_valid, rd_data      in-order read responses, no back-pressure
//   fmi_we, fmi_addr, fmi_wdata FMI tile RAM write port
// -----------------------------------------------------------------------------
module fmi_tile_loader
    import irb_pkg::*;
#(
    parameter int PX_W    = irb_pkg::PX_W,
    parameter int TIX     = irb_pkg::TIX,
    parameter int TIY     = irb_pkg::TIY,
    parameter int TIF     = irb_pkg::TIF,
    parameter int PAD     = irb_pkg::PAD,
    parameter int MAX_OUT = irb_pkg::MAX_OUT,
    parameter int FMI_AW  = irb_pkg::FMI_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       cfg_base,
    input  logic [4:0]        cfg_nif,
    input  logic [7:0]        cfg_nix,
    input  logic [7:0]        cfg_niy,
    input  logic [7:0]        cfg_tx,
    input  logic [7:0]        cfg_ty,
    output logic              busy,
    output logic              done,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [31:0]       rd_addr,
    input  logic              rd_data_valid,
    input  logic [PX_W-1:0]   rd_data,
    output logic              fmi_we,
    output logic [FMI_AW-1:0] fmi_addr,
    output logic [PX_W-1:0]   fmi_wdata
);

    localparam int LX_W  = (TIX > 1) ? $clog2(TIX) : 1;
    localparam int LY_W  = (TIY > 1) ? $clog2(TIY) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int OCC_W = CNT_W + 1;

    fmil_state_t state, state_nxt;

    // Captured configuration
    logic [31:0] base_q;
    logic [4:0]  nif_q;
    logic [7:0]  nix_q, niy_q, tx_q, ty_q;

    // Scan position and its RAM address
    logic [4:0]        c_q;
    logic [LY_W-1:0]   ly_q;
    logic [LX_W-1:0]   lx_q;
    logic [FMI_AW-1:0] idx_q;
    logic [FMI_AW-1:0] req_idx_q;   // RAM address of the request on rd_addr

    logic [9:0]        gx, gy;
    logic              is_pad, is_last;
    logic [31:0]       rd_addr_nxt;
    logic              push, pop, credit;
    logic              advance, load_req, zero_wr;
    logic [OCC_W-1:0]  occ;
    logic [CNT_W-1:0]  count;
    logic              full, empty;
    logic [FMI_AW-1:0] head_idx;

    // Global coordinates in 10-bit two's complement: tx+lx stays below 512,
    // so bit 9 is set only when the halo reaches left of / above the image.
    always_comb begin
        gx          = 10'(tx_q) + 10'(lx_q) - 10'(PAD);
        gy          = 10'(ty_q) + 10'(ly_q) - 10'(PAD);
        is_pad      = gx[9] || (gx >= 10'(nix_q)) || gy[9] || (gy >= 10'(niy_q));
        rd_addr_nxt = base_q + (32'(c_q) * 32'(niy_q) + 32'(gy)) * 32'(nix_q) + 32'(gx);
        is_last     = (c_q == nif_q - 5'd1) && (ly_q == LY_W'(TIY - 1))
                      && (lx_q == LX_W'(TIX - 1));
    end

    assign push = rd_req_valid && rd_req_ready;
    // Responses outside a tile have no destination and are dropped.
    assign pop  = rd_data_valid && !empty && (state != IDLE);

    // A request waiting on rd_addr already holds a credit; it moves into the
    // FIFO on its handshake, so occupancy is FIFO + pending - this cycle's pop.
    assign occ    = OCC_W'(count) + OCC_W'(rd_req_valid) - OCC_W'(pop);
    assign credit = (occ < OCC_W'(MAX_OUT));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        load_req  = 1'b0;
        zero_wr   = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                if (is_pad) begin
                    // The write port belongs to the response this cycle.
                    zero_wr = !pop;
                    advance = !pop;
                end else begin
                    load_req = (!rd_req_valid || rd_req_ready) && credit;
                    advance  = load_req;
                end
                if (advance && is_last) state_nxt = DRAIN;
            end
            DRAIN: if (empty && !rd_req_valid) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q       <= '0;
            nif_q        <= '0;
            nix_q        <= '0;
            niy_q        <= '0;
            tx_q         <= '0;
            ty_q         <= '0;
            c_q          <= '0;
            ly_q         <= '0;
            lx_q         <= '0;
            idx_q        <= '0;
            req_idx_q    <= '0;
            rd_req_valid <= 1'b0;
            rd_addr      <= '0;
            fmi_we       <= 1'b0;
            fmi_addr     <= '0;
            fmi_wdata    <= '0;
        end else begin
            if (state == IDLE && start) begin
                base_q <= cfg_base;
                nif_q  <= cfg_nif;
                nix_q  <= cfg_nix;
                niy_q  <= cfg_niy;
                tx_q   <= cfg_tx;
                ty_q   <= cfg_ty;
                c_q    <= '0;
                ly_q   <= '0;
                lx_q   <= '0;
                idx_q  <= '0;
            end else if (advance) begin
                idx_q <= idx_q + 1'b1;
                if (lx_q == LX_W'(TIX - 1)) begin
                    lx_q <= '0;
                    if (ly_q == LY_W'(TIY - 1)) begin
                        ly_q <= '0;
                        c_q  <= c_q + 1'b1;
                    end else begin
                        ly_q <= ly_q + 1'b1;
                    end
                end else begin
                    lx_q <= lx_q + 1'b1;
                end
            end

            // rd_addr only changes when no request is waiting or it is taken.
            if (load_req) begin
                rd_req_valid <= 1'b1;
                rd_addr      <= rd_addr_nxt;
                req_idx_q    <= idx_q;
            end else if (rd_req_ready) begin
                rd_req_valid <= 1'b0;
            end

            if (pop) begin
                fmi_we    <= 1'b1;
                fmi_addr  <= head_idx;
                fmi_wdata <= rd_data;
            end else if (zero_wr) begin
                fmi_we    <= 1'b1;
                fmi_addr  <= idx_q;
                fmi_wdata <= '0;
            end else begin
                fmi_we    <= 1'b0;
            end
        end
    end

    // The credit rule keeps FIFO + pending request within MAX_OUT.
    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && full && !pop));
    end

    irb_addr_fifo #(
        .W     (FMI_AW),
        .DEPTH (MAX_OUT)
    ) u_addr_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (req_idx_q),
        .pop   (pop),
        .dout  (head_idx),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_fmi_tile_loader.sv
// -----------------------------------------------------------------------------
// tb_fmi_tile_loader
// Directed bench for fmi_tile_loader. A memory responder answers each
// accepted read with data = low bits of the address after a programmable
// delay; a monitor records FMI RAM writes, read addresses and done pulses.
// -----------------------------------------------------------------------------
module tb_fmi_tile_loader;
    import irb_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [31:0]       cfg_base;
    logic [4:0]        cfg_nif;
    logic [7:0]        cfg_nix, cfg_niy, cfg_tx, cfg_ty;
    logic              busy, done;
    logic              rd_req_valid, rd_req_ready;
    logic [31:0]       rd_addr;
    logic              rd_data_valid;
    logic [PX_W-1:0]   rd_data;
    logic              fmi_we;
    logic [FMI_AW-1:0] fmi_addr;
    logic [PX_W-1:0]   fmi_wdata;

    always #5 clk = ~clk;

    fmi_tile_loader dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_base      (cfg_base),
        .cfg_nif       (cfg_nif),
        .cfg_nix       (cfg_nix),
        .cfg_niy       (cfg_niy),
        .cfg_tx        (cfg_tx),
        .cfg_ty        (cfg_ty),
        .busy          (busy),
        .done          (done),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_addr       (rd_addr),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .fmi_we        (fmi_we),
        .fmi_addr      (fmi_addr),
        .fmi_wdata     (fmi_wdata)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    rsp_t rsp_q[$];

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int delay = 1;
    bit rand_ready = 1'b0;

    int rd_count, rsp_count, we_count, zero_count, done_count;
    int max_out, stall_err, last_we_cyc, done_cyc;
    logic [31:0]       first_rd, last_rd, prev_addr;
    logic              prev_stall;
    logic [FMI_AW-1:0] last_we_addr;
    logic [PX_W-1:0]   mem [FMI_N_ELEM];

    // Configuration of the tile currently being loaded (for the RAM model)
    logic [31:0] cur_base;
    int cur_nif, cur_nix, cur_niy, cur_tx, cur_ty;

    // Status captured by run_tile
    int cycles, busy_low;
    bit tile_ok;
    logic busy_at_done, busy_after;

    // Responder and monitor: all sampling on the falling edge.
    initial begin
        rd_data_valid = 1'b0;
        rd_data       = '0;
        rd_req_ready  = 1'b1;
        prev_stall    = 1'b0;
        prev_addr     = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                rd_data_valid = 1'b1;
                rd_data       = rsp_q[0].addr[PX_W-1:0];
                void'(rsp_q.pop_front());
                rsp_count++;
            end else begin
                rd_data_valid = 1'b0;
                rd_data       = '0;
            end
            rd_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall && (rd_req_valid !== 1'b1 || rd_addr !== prev_addr)) stall_err++;
            prev_stall = rd_req_valid && !rd_req_ready;
            prev_addr  = rd_addr;
            if (rd_req_valid && rd_req_ready) begin
                if (rd_count == 0) first_rd = rd_addr;
                last_rd = rd_addr;
                rd_count++;
                rsp_q.push_back('{addr: rd_addr, due: cyc + delay});
            end
            if (rd_count - rsp_count > max_out) max_out = rd_count - rsp_count;
            if (fmi_we === 1'b1) begin
                if (int'(fmi_addr) < FMI_N_ELEM) mem[fmi_addr] = fmi_wdata;
                we_count++;
                if (fmi_wdata == '0) zero_count++;
                last_we_addr = fmi_addr;
                last_we_cyc  = cyc;
            end
            if (done === 1'b1) begin
                done_count++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_stats();
        rd_count = 0; rsp_count = 0; we_count = 0; zero_count = 0; done_count = 0;
        max_out = 0; stall_err = 0; last_we_cyc = -1; done_cyc = -1;
        first_rd = '0; last_rd = '0; last_we_addr = '0; prev_stall = 1'b0;
        rsp_q.delete();
        for (int i = 0; i < FMI_N_ELEM; i++) mem[i] = 16'hDEAD;
    endtask

    // Expected RAM word for one element of the current tile.
    function automatic logic [PX_W-1:0] exp_val(input int c, input int ly, input int lx);
        int gx, gy;
        logic [31:0] a;
        gx = cur_tx + lx - PAD;
        gy = cur_ty + ly - PAD;
        if (gx < 0 || gx >= cur_nix || gy < 0 || gy >= cur_niy) return '0;
        a = cur_base + 32'((c * cur_niy + gy) * cur_nix + gx);
        return a[PX_W-1:0];
    endfunction

    function automatic int ram_mismatches(output int first_bad);
        int n = 0;
        first_bad = -1;
        for (int c = 0; c < cur_nif; c++)
            for (int ly = 0; ly < TIY; ly++)
                for (int lx = 0; lx < TIX; lx++) begin
                    int idx = c * TIX * TIY + ly * TIX + lx;
                    if (mem[idx] !== exp_val(c, ly, lx)) begin
                        if (first_bad < 0) first_bad = idx;
                        n++;
                    end
                end
        return n;
    endfunction

    task automatic drive_cfg(input logic [31:0] base, input int nif, input int nix,
                             input int niy, input int tx, input int ty);
        cfg_base = base;
        cfg_nif  = 5'(nif);
        cfg_nix  = 8'(nix);
        cfg_niy  = 8'(niy);
        cfg_tx   = 8'(tx);
        cfg_ty   = 8'(ty);
        cur_base = base; cur_nif = nif; cur_nix = nix; cur_niy = niy;
        cur_tx = tx; cur_ty = ty;
    endtask

    // Starts one tile and waits (bounded) for done.
    task automatic run_tile(input logic [31:0] base, input int nif, input int nix,
                            input int niy, input int tx, input int ty, input bit inject);
        int n;
        @(posedge clk); #1;
        clear_stats();
        @(negedge clk);
        drive_cfg(base, nif, nix, niy, tx, ty);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        busy_low = 0;
        tile_ok  = 1'b0;
        n        = 0;
        while (n < 6000) begin
            if (done === 1'b1) begin
                tile_ok = 1'b1;
                break;
            end
            if (busy !== 1'b1) busy_low++;
            if (inject && n == 50) begin
                start = 1'b1; cfg_tx = 8'd0; cfg_ty = 8'd0; cfg_nif = 5'd1;
            end else if (inject && n == 51) begin
                start = 1'b0; drive_cfg(base, nif, nix, niy, tx, ty);
            end
            @(negedge clk);
            n++;
        end
        cycles       = n + 1;
        busy_at_done = busy;
        if (inject) start = 1'b1;  // coincides with done
        @(negedge clk);
        start      = 1'b0;
        busy_after = busy;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (rd_req_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_req_valid got=%b want=0", rd_req_valid); end
        checks++; if (rd_addr !== 32'h0) begin errors++; $display("FAIL reset_rd_addr got=%h want=0", rd_addr); end
        checks++; if (fmi_we !== 1'b0) begin errors++; $display("FAIL reset_fmi_we got=%b want=0", fmi_we); end
        checks++; if (fmi_addr !== '0) begin errors++; $display("FAIL reset_fmi_addr got=%0d want=0", fmi_addr); end
        checks++; if (fmi_wdata !== '0) begin errors++; $display("FAIL reset_fmi_wdata got=%h want=0", fmi_wdata); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_interior();
        int bad, first_bad;
        run_tile(32'h100, 1, 8, 8, 3, 3, 1'b0);
        checks++; if (!tile_ok) begin errors++; $display("FAIL interior_timeout got=no_done want=done"); end
        checks++; if (rd_count != 25) begin errors++; $display("FAIL interior_reads got=%0d want=25", rd_count); end
        checks++; if (first_rd !== 32'h112) begin errors++; $display("FAIL interior_first_rd got=%h want=112", first_rd); end
        checks++; if (last_rd !== 32'h136) begin errors++; $display("FAIL interior_last_rd got=%h want=136", last_rd); end
        checks++; if (we_count != 25) begin errors++; $display("FAIL interior_writes got=%0d want=25", we_count); end
        bad = ram_mismatches(first_bad);
        checks++; if (bad != 0) begin errors++; $display("FAIL interior_ram got=%0d_bad(first %0d) want=0", bad, first_bad); end
        checks++; if (done_count != 1) begin errors++; $display("FAIL interior_done_pulses got=%0d want=1", done_count); end
        checks++; if (done_cyc != last_we_cyc + 1) begin errors++; $display("FAIL interior_done_timing got=%0d want=%0d", done_cyc, last_we_cyc + 1); end
        checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL interior_busy_at_done got=%b want=0", busy_at_done); end
        checks++; if (cycles > 31) begin errors++; $display("FAIL interior_throughput got=%0d want<=31", cycles); end
    endtask

    task automatic test_corner();
        int bad, first_bad;
        run_tile(32'h100, 1, 8, 8, 0, 0, 1'b0);
        checks++; if (!tile_ok) begin errors++; $display("FAIL corner_timeout got=no_done want=done"); end
        checks++; if (zero_count != 9) begin errors++; $display("FAIL corner_zero_writes got=%0d want=9", zero_count); end
        checks++; if (rd_count != 16) begin errors++; $display("FAIL corner_reads got=%0d want=16", rd_count); end
        checks++; if (first_rd !== 32'h100) begin errors++; $display("FAIL corner_first_rd got=%h want=100", first_rd); end
        checks++; if (mem[20] !== 16'h0) begin errors++; $display("FAIL corner_ram20 got=%h want=0", mem[20]); end
        checks++; if (mem[6] !== 16'h0100) begin errors++; $display("FAIL corner_ram6 got=%h want=0100", mem[6]); end
        bad = ram_mismatches(first_bad);
        checks++; if (bad != 0) begin errors++; $display("FAIL corner_ram got=%0d_bad(first %0d) want=0", bad, first_bad); end
    endtask

    task automatic test_edge();
        int bad, first_bad;
        run_tile(32'h100, 1, 4, 4, 3, 3, 1'b0);
        checks++; if (!tile_ok) begin errors++; $display("FAIL edge_timeout got=no_done want=done"); end
        checks++; if (rd_count != 4) begin errors++; $display("FAIL edge_reads got=%0d want=4", rd_count); end
        checks++; if (zero_count != 21) begin errors++; $display("FAIL edge_zero_writes got=%0d want=21", zero_count); end
        checks++; if (first_rd !== 32'h10A) begin errors++; $display("FAIL edge_first_rd got=%h want=10a", first_rd); end
        checks++; if (last_rd !== 32'h10F) begin errors++; $display("FAIL edge_last_rd got=%h want=10f", last_rd); end
        bad = ram_mismatches(first_bad);
        checks++; if (bad != 0) begin errors++; $display("FAIL edge_ram got=%0d_bad(first %0d) want=0", bad, first_bad); end
    endtask

    task automatic test_backpressure();
        int bad, first_bad;
        delay      = 10;
        rand_ready = 1'b1;
        run_tile(32'h100, 1, 8, 8, 3, 3, 1'b0);
        rand_ready = 1'b0;
        delay      = 1;
        checks++; if (!tile_ok) begin errors++; $display("FAIL bp_timeout got=no_done want=done"); end
        checks++; if (max_out > 4) begin errors++; $display("FAIL bp_outstanding got=%0d want<=4", max_out); end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_addr_stable got=%0d_changes want=0", stall_err); end
        checks++; if (rd_count != 25) begin errors++; $display("FAIL bp_reads got=%0d want=25", rd_count); end
        bad = ram_mismatches(first_bad);
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_ram got=%0d_bad(first %0d) want=0", bad, first_bad); end
        checks++; if (done_count != 1) begin errors++; $display("FAIL bp_done_pulses got=%0d want=1", done_count); end
    endtask

    task automatic test_full_depth();
        int bad, first_bad;
        run_tile(32'h1000_0000, 16, 16, 16, 5, 5, 1'b1);
        checks++; if (!tile_ok) begin errors++; $display("FAIL full_timeout got=no_done want=done"); end
        checks++; if (we_count != 400) begin errors++; $display("FAIL full_writes got=%0d want=400", we_count); end
        checks++; if (rd_count != 400) begin errors++; $display("FAIL full_reads got=%0d want=400", rd_count); end
        checks++; if (last_we_addr !== 9'd399) begin errors++; $display("FAIL full_last_addr got=%0d want=399", last_we_addr); end
        checks++; if (first_rd !== 32'h1000_0044) begin errors++; $display("FAIL full_first_rd got=%h want=10000044", first_rd); end
        checks++; if (last_rd !== 32'h1000_0F88) begin errors++; $display("FAIL full_last_rd got=%h want=10000f88", last_rd); end
        checks++; if (busy_low != 0) begin errors++; $display("FAIL full_busy got=%0d_low_cycles want=0", busy_low); end
        bad = ram_mismatches(first_bad);
        checks++; if (bad != 0) begin errors++; $display("FAIL full_ram got=%0d_bad(first %0d) want=0", bad, first_bad); end
        checks++; if (done_count != 1) begin errors++; $display("FAIL full_done_pulses got=%0d want=1", done_count); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL full_start_at_done got=busy_%b want=0", busy_after); end
    endtask

    task automatic test_reset_mid_tile();
        int n, stale_we, busy_hi, bad, first_bad;
        @(posedge clk); #1;
        clear_stats();
        delay = 10;
        @(negedge clk);
        drive_cfg(32'h1000_0000, 16, 16, 16, 5, 5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (rd_count < 30 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (rd_count < 30) begin errors++; $display("FAIL midrst_wait got=%0d_reads want=30", rd_count); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({busy, done, rd_req_valid, fmi_we} !== 4'b0000)
            begin errors++; $display("FAIL midrst_flags got=%b want=0000", {busy, done, rd_req_valid, fmi_we}); end
        checks++; if (rd_addr !== 32'h0 || fmi_addr !== '0 || fmi_wdata !== '0)
            begin errors++; $display("FAIL midrst_values got=%h/%0d/%h want=0/0/0", rd_addr, fmi_addr, fmi_wdata); end
        stale_we = 0;
        busy_hi  = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (fmi_we !== 1'b0) stale_we++;
            if (busy !== 1'b0) busy_hi++;
        end
        checks++; if (stale_we != 0) begin errors++; $display("FAIL midrst_stale_writes got=%0d want=0", stale_we); end
        checks++; if (busy_hi != 0) begin errors++; $display("FAIL midrst_idle got=%0d_busy_cycles want=0", busy_hi); end
        delay = 1;
        run_tile(32'h100, 1, 8, 8, 3, 3, 1'b0);
        checks++; if (!tile_ok) begin errors++; $display("FAIL midrst_retile_timeout got=no_done want=done"); end
        checks++; if (we_count != 25) begin errors++; $display("FAIL midrst_retile_writes got=%0d want=25", we_count); end
        bad = ram_mismatches(first_bad);
        checks++; if (bad != 0) begin errors++; $display("FAIL midrst_retile_ram got=%0d_bad(first %0d) want=0", bad, first_bad); end
        checks++; if (done_count != 1) begin errors++; $display("FAIL midrst_retile_done got=%0d want=1", done_count); end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        drive_cfg(32'h0, 1, 1, 1, 0, 0);
        test_reset();
        test_interior();
        test_corner();
        test_edge();
        test_backpressure();
        test_full_depth();
        test_reset_mid_tile();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
